// File: rtl/sign_ext.sv
// LEGv8 immediate generator: opcode decode plus sign/zero extension to 64 bits,
// with a registered copy of the result and a validity flag.
// Ports: clk, reset (async, active-high), a[31:0] instruction,
//   y[63:0] combinational immediate, unk combinational unknown-opcode flag,
//   y_q[63:0] registered y, y_valid_q registered ~unk.
// Optional macro SIGNEXT_BRANCH_SHIFT_EN: branch offsets (CBZ/CBNZ/B/BL)
//   are shifted left by 2 to give byte offsets.
module sign_ext (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  output logic [63:0] y,
  output logic        unk,
  output logic [63:0] y_q,
  output logic        y_valid_q
);

  logic        is_mem;
  logic        is_cb;
  logic        is_b;
  logic        is_ai;
  logic [63:0] y_d;
  logic        y_valid_d;

  // Encodings are mutually exclusive, so the decode needs no priority.
  assign is_mem = (a[31:21] == 11'b111_1100_0010)
               || (a[31:21] == 11'b111_1100_0000);
  assign is_cb  = (a[31:24] == 8'b1011_0100)
               || (a[31:24] == 8'b1011_0101);
  assign is_b   = (a[31:26] == 6'b000101)
               || (a[31:26] == 6'b100101);
  assign is_ai  = (a[31:22] == 10'b1001000100)
               || (a[31:22] == 10'b1101000100);

  function automatic logic [63:0] br_off(input logic [63:0] v);
`ifdef SIGNEXT_BRANCH_SHIFT_EN
    br_off = {v[61:0], 2'b00};
`else
    br_off = v;
`endif
  endfunction

  always_comb begin
    y   = 64'h0;
    unk = 1'b0;
    unique case (1'b1)
      is_mem:  y = {{55{a[20]}}, a[20:12]};
      is_cb:   y = br_off({{45{a[23]}}, a[23:5]});
      is_b:    y = br_off({{38{a[25]}}, a[25:0]});
      is_ai:   y = {52'h0, a[21:10]};
      default: unk = 1'b1;
    endcase
  end

  always_comb begin
    y_d       = y;
    y_valid_d = ~unk;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q       <= 64'h0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

endmodule

// File: tb/tb_sign_ext.sv
// Self-checking bench for sign_ext: arithmetic reference model,
// per-cycle compare process and directed literal vectors.
module tb_sign_ext;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = 32'h0;
  logic [63:0] y;
  logic        unk;
  logic [63:0] y_q;
  logic        y_valid_q;

  int total = 0;
  int bad = 0;

  sign_ext dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .y         (y),
    .unk       (unk),
    .y_q       (y_q),
    .y_valid_q (y_valid_q)
  );

  always #5 clk = ~clk;

  function automatic longint sext(input longint x, input int n);
    longint s;
    s = x << (64 - n);
    return s >>> (64 - n);
  endfunction

  // Returns {unk, y}.
  function automatic logic [64:0] model(input logic [31:0] w);
    longint v;
    logic   u;
    v = 0;
    u = 1'b0;
    if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000)
      v = sext(longint'(w[20:12]), 9);
    else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5) begin
      v = sext(longint'(w[23:5]), 19);
`ifdef SIGNEXT_BRANCH_SHIFT_EN
      v = v * 4;
`endif
    end else if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
      v = sext(longint'(w[25:0]), 26);
`ifdef SIGNEXT_BRANCH_SHIFT_EN
      v = v * 4;
`endif
    end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100)
      v = longint'(w[21:10]);
    else
      u = 1'b1;
    return {u, 64'(v)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Registered expectation, derived from the model.
  logic [63:0] exp_yq;
  logic        exp_vq;
  always @(posedge clk or posedge reset) begin
    logic [64:0] m;
    m = model(a);
    if (reset) begin
      exp_yq <= 64'h0;
      exp_vq <= 1'b0;
    end else begin
      exp_yq <= m[63:0];
      exp_vq <= ~m[64];
    end
  end

  always @(negedge clk) begin
    logic [64:0] m;
    m = model(a);
    chk("cyc_y", y, m[63:0]);
    chk("cyc_unk", {63'h0, unk}, {63'h0, m[64]});
    chk("cyc_y_q", y_q, exp_yq);
    chk("cyc_vq", {63'h0, y_valid_q}, {63'h0, exp_vq});
  end

  task automatic lit(input string nm, input logic [31:0] w,
                     input logic [63:0] ey, input logic eu);
    logic [64:0] m;
    a = w;
    #1;
    m = model(w);
    chk({nm, "_y"}, y, ey);
    chk({nm, "_unk"}, {63'h0, unk}, {63'h0, eu});
    chk({nm, "_model"}, m[63:0], ey);
  endtask

  logic [63:0] cb_p;
  logic [63:0] cb_n;

  initial begin
`ifdef SIGNEXT_BRANCH_SHIFT_EN
    cb_p = 64'h0000_0000_0007_8FE8;
    cb_n = 64'hFFFF_FFFF_FFF7_8FE8;
`else
    cb_p = 64'h0000_0000_0001_E3FA;
    cb_n = 64'hFFFF_FFFF_FFFD_E3FA;
`endif
    #2;
    chk("rst_y_q", y_q, 64'h0);
    chk("rst_vq", {63'h0, y_valid_q}, 64'h0);
    lit("rst_y_unk", 32'h0, 64'h0, 1'b1);
    @(posedge clk); #2;
    reset = 1'b0;

    lit("ldur_pos", 32'hF84E3136, 64'h0000_0000_0000_00E3, 1'b0);
    @(posedge clk); #2;
    lit("stur_pos", 32'hF80E3136, 64'h0000_0000_0000_00E3, 1'b0);
    @(posedge clk); #2;
    lit("ldur_neg", 32'hF85E3136, 64'hFFFF_FFFF_FFFF_FFE3, 1'b0);
    @(posedge clk); #2;
    lit("stur_neg", 32'hF81E3136, 64'hFFFF_FFFF_FFFF_FFE3, 1'b0);
    @(posedge clk); #2;
    lit("ldur_min", 32'hF8500000, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    @(posedge clk); #2;
    lit("ldur_zero", 32'hF84003FF, 64'h0, 1'b0);
    @(posedge clk); #2;
    lit("cbz_pos", 32'hB43C7F56, cb_p, 1'b0);
    @(posedge clk); #2;
    lit("cbz_neg", 32'hB4BC7F56, cb_n, 1'b0);
    @(posedge clk); #2;
    lit("cbnz_neg", 32'hB5BC7F56, cb_n, 1'b0);
    @(posedge clk); #2;
`ifdef SIGNEXT_BRANCH_SHIFT_EN
    lit("b_ones", 32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    @(posedge clk); #2;
    lit("b_one", 32'h14000001, 64'h4, 1'b0);
`else
    lit("b_ones", 32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(posedge clk); #2;
    lit("b_one", 32'h14000001, 64'h1, 1'b0);
`endif
    @(posedge clk); #2;
    lit("b_max", 32'h15FFFFFF, model(32'h15FFFFFF) & 65'h0_FFFF_FFFF_FFFF_FFFF,
        1'b0);
    @(posedge clk); #2;
    lit("addi_fff", 32'h913FFFFF, 64'h0000_0000_0000_0FFF, 1'b0);
    @(posedge clk); #2;
    lit("subi_fff", 32'hD13FFFFF, 64'h0000_0000_0000_0FFF, 1'b0);
    @(posedge clk); #2;
    lit("unk_zero", 32'h0, 64'h0, 1'b1);
    @(posedge clk); #2;
    lit("unk_ones", 32'hFFFFFFFF, 64'h0, 1'b1);
    @(posedge clk); #2;

    // Field isolation: bits outside opcode/immediate must not matter.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      w = 32'hF85E3000 | 32'($urandom_range(0, 4095));
      lit("iso", w, 64'hFFFF_FFFF_FFFF_FFE3, 1'b0);
      @(posedge clk); #2;
    end

    // Registered path and asynchronous reset.
    a = 32'hF84E3136;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_y_q", y_q, 64'h0);
    chk("arst_vq", {63'h0, y_valid_q}, 64'h0);
    lit("arst_y", 32'hF84E3136, 64'h0000_0000_0000_00E3, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    a = 32'hF85E3136;
    @(posedge clk); #1;
    chk("reg_y_q", y_q, 64'hFFFF_FFFF_FFFF_FFE3);
    chk("reg_vq", {63'h0, y_valid_q}, 64'h1);
    a = 32'h0;
    @(posedge clk); #1;
    chk("reg_vq0", {63'h0, y_valid_q}, 64'h0);
    chk("reg_yq0", y_q, 64'h0);

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
